// File: rtl/mips_32bits_register_file_pkg.sv
// Shared constants for the MIPS register file, the instruction decoder and the shifter.
package mips_32bits_register_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_INIT_C = 32'h0000_2FFC;
  localparam logic [31:0] GP_INIT_C = 32'h0000_1800;

  // Shift-mode codes agreed between the decoder and the shifter
  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_mode_e;

endpackage

// File: rtl/mips_32bits_register_file_read_port.sv
// One combinational read port: array mux, optional write-to-read forwarding, r0 forced to zero.
module mips_regfile_read_port
  import mips_32bits_register_file_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH,
  parameter int NUM_REGS_P   = 1 << ADDR_WIDTH_P,
  parameter bit BYPASS       = 1'b1
) (
  input  logic [NUM_REGS_P-1:0][DATA_WIDTH_P-1:0] regs_i,
  input  logic [ADDR_WIDTH_P-1:0]                 rd_addr_i,
  input  logic                                    wr_en_i,
  input  logic [ADDR_WIDTH_P-1:0]                 wr_addr_i,
  input  logic [DATA_WIDTH_P-1:0]                 wr_data_i,
  output logic [DATA_WIDTH_P-1:0]                 rd_data_o
);

  // Zero-forcing is applied last so a pending write to r0 can never leak through the bypass
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    if (BYPASS && (wr_en_i == 1'b1) && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
    if (rd_addr_i == '0) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/mips_32bits_register_file.sv
// MIPS 32-entry register file with two forwarded read ports, shift-amount select and write counter.
module mips_32bits_register_file
  import mips_32bits_register_file_pkg::*;
#(
  parameter int          DATA_WIDTH = mips_32bits_register_file_pkg::DATA_WIDTH,
  parameter int          ADDR_WIDTH = mips_32bits_register_file_pkg::ADDR_WIDTH,
  parameter bit          BYPASS     = 1'b1,
  parameter logic [31:0] SP_INIT    = SP_INIT_C,
  parameter logic [31:0] GP_INIT    = GP_INIT_C
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [ADDR_WIDTH-1:0] Read_addr_1,
  input  logic [ADDR_WIDTH-1:0] Read_addr_2,
  input  logic [ADDR_WIDTH-1:0] Write_addr,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  Write_enable,
  input  logic [4:0]            Shamt_imm,
  input  logic                  Shamt_variable,
  output logic [DATA_WIDTH-1:0] Read_data_1,
  output logic [DATA_WIDTH-1:0] Read_data_2,
  output logic [4:0]            Shift_amount_out,
  output logic [15:0]           Write_count
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [15:0]                         wr_count_q;
  logic [15:0]                         wr_count_d;
  logic                                wr_commit;

  // An X/Z enable evaluates false in the if below, so it never commits
  assign wr_commit  = (Write_enable == 1'b1) && (Write_addr != '0);
  assign wr_count_d = wr_count_q + 16'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == REG_GP)      regs_q[i] <= DATA_WIDTH'(GP_INIT);
        else if (i == REG_SP) regs_q[i] <= DATA_WIDTH'(SP_INIT);
        else                  regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wr_commit) begin
      regs_q[Write_addr] <= Write_data;
      wr_count_q         <= wr_count_d;
    end
  end

  mips_regfile_read_port #(
    .DATA_WIDTH_P(DATA_WIDTH),
    .ADDR_WIDTH_P(ADDR_WIDTH),
    .NUM_REGS_P  (NUM_REGS),
    .BYPASS      (BYPASS)
  ) u_rd_port_1 (
    .regs_i   (regs_q),
    .rd_addr_i(Read_addr_1),
    .wr_en_i  (Write_enable),
    .wr_addr_i(Write_addr),
    .wr_data_i(Write_data),
    .rd_data_o(Read_data_1)
  );

  mips_regfile_read_port #(
    .DATA_WIDTH_P(DATA_WIDTH),
    .ADDR_WIDTH_P(ADDR_WIDTH),
    .NUM_REGS_P  (NUM_REGS),
    .BYPASS      (BYPASS)
  ) u_rd_port_2 (
    .regs_i   (regs_q),
    .rd_addr_i(Read_addr_2),
    .wr_en_i  (Write_enable),
    .wr_addr_i(Write_addr),
    .wr_data_i(Write_data),
    .rd_data_o(Read_data_2)
  );

  // Variable shifts take the forwarded rs value so back-to-back sllv sees fresh data
  assign Shift_amount_out = Shamt_variable ? Read_data_1[4:0] : Shamt_imm;
  assign Write_count      = wr_count_q;

endmodule

// File: doc/mips_32bits_register_file.md
MIPS_32BITS_REGISTER_FILE -- requirements
Module: mips_32bits_register_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase names them: Clk (clock) and Reset_n (reset).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the register width.
REQ-003 Parameter ADDR_WIDTH, default 5, SHALL set the address width (32 registers).
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when set to 1.
REQ-005 Parameter SP_INIT, default 32'h0000_2FFC, SHALL be the reset value of register 29.
REQ-006 Parameter GP_INIT, default 32'h0000_1800, SHALL be the reset value of register 28.
REQ-007 Clk  input  1  rising-edge clock.
REQ-008 Reset_n  input  1  asynchronous reset, active low.
REQ-009 Read_addr_1  input  5  rs address.
REQ-010 Read_addr_2  input  5  rt address.
REQ-011 Write_addr  input  5  rd or rt destination address.
REQ-012 Write_data  input  32  writeback value.
REQ-013 Write_enable  input  1  commits Write_data at the next rising edge.
REQ-014 Shamt_imm  input  5  instruction shamt field.
REQ-015 Shamt_variable  input  1  1 selects rs[4:0] as the shift amount (sllv/srlv/srav).
REQ-016 Read_data_1  output  32  rs value.
REQ-017 Read_data_2  output  32  rt value; this is the shifter's data operand.
REQ-018 Shift_amount_out  output  5  shift amount fed to the shifter's Shift_amount input.
REQ-019 Write_count  output  16  number of committed writes since reset.

Function
REQ-020 The read ports SHALL be combinational, with zero-cycle latency from address to data.
REQ-021 A write SHALL commit on a rising edge of Clk when Write_enable=1 and Write_addr!=0.
REQ-022 Register 0 SHALL always read 0; a write to address 0 SHALL be ignored and SHALL NOT increment Write_count.
REQ-023 With BYPASS=1, a read whose address equals Write_addr (non-zero) while Write_enable=1 SHALL return Write_data in the same cycle.
REQ-024 With BYPASS=0, that same read SHALL return the old value until the commit edge.
REQ-025 When both read ports address the same register, both SHALL return identical data, bypass included.
REQ-026 Shift_amount_out SHALL equal Read_data_1[4:0] (post-bypass) when Shamt_variable=1, and Shamt_imm otherwise.
REQ-027 Write_count SHALL increment by 1 per committed write and SHALL wrap from 16'hFFFF to 0.
REQ-028 Write_count SHALL remain constant when Write_enable=0 or Write_addr=0.
REQ-029 Inputs that are X or Z on Write_enable SHALL be treated as no-write.

Reset
REQ-030 While Reset_n=0, all registers SHALL be 0 except r28=GP_INIT and r29=SP_INIT.
REQ-031 While Reset_n=0, Write_count SHALL be 0.
REQ-032 Reset SHALL act immediately on assertion, independent of Clk.
REQ-033 A write coinciding with a clock edge during reset SHALL be discarded.
REQ-034 The first write SHALL occur at the first rising edge after Reset_n deasserts.
REQ-035 During reset, read outputs SHALL reflect the reset values combinationally; bypass still applies.

Structure
REQ-036 A shared package SHALL hold DATA_WIDTH, ADDR_WIDTH, the register indices ZERO=0, GP=28, SP=29 and RA=31, and the SP/GP reset constants.
REQ-037 The shift-mode codes (0 logical left, 1 logical right, 2 arithmetic right, 3 rotate right) SHALL move to the same package for shared use by the decoder and the shifter.
REQ-038 A single sub-module, mips_regfile_read_port, SHALL implement one read port (array mux, zero-forcing, bypass), instantiated twice.
REQ-039 The block SHALL NOT contain the shifter itself.

Verification
REQ-040 Reset: assert Reset_n=0 mid-cycle -> all reads return 0 immediately, r29=32'h0000_2FFC, r28=32'h0000_1800, Write_count=0.
REQ-041 Write r5=32'hDEAD_BEEF, then read addr1=addr2=5 -> both outputs 32'hDEAD_BEEF and Write_count=1.
REQ-042 Write r0=32'hFFFF_FFFF -> Read_data_1 at addr 0 is 0 and Write_count is unchanged.
REQ-043 BYPASS=1: Write_enable=1, Write_addr=7, Write_data=32'h0000_0013, Read_addr_1=7, Shamt_variable=1 -> same cycle Read_data_1=32'h13 and Shift_amount_out=5'd19; with BYPASS=0 -> old value.
REQ-044 Shamt_variable=0, Shamt_imm=5'd31 -> Shift_amount_out=31 regardless of rs.
REQ-045 Perform 65537 writes to r1 -> Write_count=1 (wrap), and r1 holds the last value written.
